pep_ks_lb_sequencer: RTL and testbench

- Parametrised loop-block sequencer for the key-switch datapath.
- Takes one KS command: input BLWE size, output LWE size and decomposition level count.
- Walks the work in LBX x LBY x LBZ blocks and emits one control token per block through a valid/ready interface.
- Supports runtime sizes and partial remainder blocks, so the multiply-accumulate core no longer needs fixed-geometry counters.

---
 rtl/pep_ks_lb_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pep_ks_lb_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pep_ks_lb_sequencer.sv
// Key-switch loop-block sequencer: walks lwe_k x blwe_k x lvl in
// LBX x LBY x LBZ blocks and emits one control token per block.
module pep_ks_lb_sequencer #(
  parameter int LBX        = 6,
  parameter int LBY        = 64,
  parameter int LBZ        = 3,
  parameter int BLWE_K_MAX = 4096,
  parameter int LWE_K_MAX  = 1024,
  parameter int LVL_MAX    = 8
) (
  input  logic                             clk,
  input  logic                             a_rst,
  input  logic                             cmd_vld,
  output logic                             cmd_rdy,
  input  logic [$clog2(BLWE_K_MAX+1)-1:0]  cmd_blwe_k,
  input  logic [$clog2(LWE_K_MAX+1)-1:0]   cmd_lwe_k,
  input  logic [$clog2(LVL_MAX+1)-1:0]     cmd_lvl,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic [$clog2(LWE_K_MAX)-1:0]     out_x_idx,
  output logic [$clog2(LBX+1)-1:0]         out_x_nb,
  output logic [$clog2(BLWE_K_MAX)-1:0]    out_y_idx,
  output logic [$clog2(LBY+1)-1:0]         out_y_nb,
  output logic [$clog2(LVL_MAX)-1:0]       out_z_idx,
  output logic [$clog2(LBZ+1)-1:0]         out_z_nb,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err
);

  localparam int BW  = $clog2(BLWE_K_MAX+1);
  localparam int LW  = $clog2(LWE_K_MAX+1);
  localparam int VW  = $clog2(LVL_MAX+1);
  localparam int XIW = $clog2(LWE_K_MAX);
  localparam int XNW = $clog2(LBX+1);
  localparam int YIW = $clog2(BLWE_K_MAX);
  localparam int YNW = $clog2(LBY+1);
  localparam int ZIW = $clog2(LVL_MAX);
  localparam int ZNW = $clog2(LBZ+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic           rdy_q, rdy_d;
  logic           err_q, err_d;
  logic [BW-1:0]  blwe_q, blwe_d;
  logic [LW-1:0]  lwe_q, lwe_d;
  logic [VW-1:0]  lvl_q, lvl_d;
  logic [LW-1:0]  x_q, x_d;
  logic [BW-1:0]  y_q, y_d;
  logic [VW-1:0]  z_q, z_d;
  logic           vld_q, vld_d;
  logic [XIW-1:0] xi_q, xi_d;
  logic [XNW-1:0] xn_q, xn_d;
  logic [YIW-1:0] yi_q, yi_d;
  logic [YNW-1:0] yn_q, yn_d;
  logic [ZIW-1:0] zi_q, zi_d;
  logic [ZNW-1:0] zn_q, zn_d;
  logic           sop_q, sop_d;
  logic           eop_q, eop_d;
  logic           last_q, last_d;

  logic           idle, acc, bad, start, gen;
  logic [BW-1:0]  s_b, c_y, y_rem;
  logic [LW-1:0]  s_l, c_x, x_rem;
  logic [VW-1:0]  s_v, c_z, z_rem;
  logic           x_last, y_last, z_last;

  // Token generator; an accepted command feeds its first token directly
  always_comb begin
    idle   = (state_q == IDLE);
    acc    = idle && rdy_q && cmd_vld;
    bad    = (cmd_lvl == '0) || (cmd_blwe_k == '0) || (cmd_lwe_k == '0)
          || (cmd_lvl > VW'(LVL_MAX))
          || (cmd_blwe_k > BW'(BLWE_K_MAX))
          || (cmd_lwe_k > LW'(LWE_K_MAX));
    start  = acc && !bad;
    s_b    = idle ? cmd_blwe_k : blwe_q;
    s_l    = idle ? cmd_lwe_k : lwe_q;
    s_v    = idle ? cmd_lvl : lvl_q;
    c_x    = idle ? '0 : x_q;
    c_y    = idle ? '0 : y_q;
    c_z    = idle ? '0 : z_q;
    x_rem  = s_l - c_x;
    y_rem  = s_b - c_y;
    z_rem  = s_v - c_z;
    x_last = (x_rem <= LW'(LBX));
    y_last = (y_rem <= BW'(LBY));
    z_last = (z_rem <= VW'(LBZ));
    gen    = (start || !idle) && (!vld_q || out_rdy);

    state_d = state_q;
    err_d   = 1'b0;
    blwe_d  = blwe_q;
    lwe_d   = lwe_q;
    lvl_d   = lvl_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    vld_d   = vld_q && !out_rdy;
    xi_d    = xi_q;
    xn_d    = xn_q;
    yi_d    = yi_q;
    yn_d    = yn_q;
    zi_d    = zi_q;
    zn_d    = zn_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    last_d  = last_q;

    if (acc) begin
      blwe_d = cmd_blwe_k;
      lwe_d  = cmd_lwe_k;
      lvl_d  = cmd_lvl;
      if (bad) begin
        err_d = 1'b1;
      end else begin
        state_d = RUN;
        x_d     = '0;
        y_d     = '0;
        z_d     = '0;
      end
    end

    if (gen) begin
      vld_d  = 1'b1;
      xi_d   = c_x[XIW-1:0];
      yi_d   = c_y[YIW-1:0];
      zi_d   = c_z[ZIW-1:0];
      xn_d   = x_last ? x_rem[XNW-1:0] : XNW'(LBX);
      yn_d   = y_last ? y_rem[YNW-1:0] : YNW'(LBY);
      zn_d   = z_last ? z_rem[ZNW-1:0] : ZNW'(LBZ);
      sop_d  = (c_y == '0) && (c_z == '0);
      eop_d  = y_last && z_last;
      last_d = y_last && z_last && x_last;
      z_d    = z_last ? '0 : c_z + VW'(LBZ);
      y_d    = c_y;
      x_d    = c_x;
      if (z_last) begin
        y_d = y_last ? '0 : c_y + BW'(LBY);
        if (y_last) begin
          x_d = x_last ? '0 : c_x + LW'(LBX);
          if (x_last) state_d = IDLE;
        end
      end
    end

    rdy_d = (state_d == IDLE);
  end

  // State, counters and output register
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      blwe_q  <= '0;
      lwe_q   <= '0;
      lvl_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      vld_q   <= 1'b0;
      xi_q    <= '0;
      xn_q    <= '0;
      yi_q    <= '0;
      yn_q    <= '0;
      zi_q    <= '0;
      zn_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      blwe_q  <= blwe_d;
      lwe_q   <= lwe_d;
      lvl_q   <= lvl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      vld_q   <= vld_d;
      xi_q    <= xi_d;
      xn_q    <= xn_d;
      yi_q    <= yi_d;
      yn_q    <= yn_d;
      zi_q    <= zi_d;
      zn_q    <= zn_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
    end
  end

  assign cmd_rdy   = rdy_q;
  assign err       = err_q;
  assign out_vld   = vld_q;
  assign out_x_idx = xi_q;
  assign out_x_nb  = xn_q;
  assign out_y_idx = yi_q;
  assign out_y_nb  = yn_q;
  assign out_z_idx = zi_q;
  assign out_z_nb  = zn_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_last  = last_q;
  assign busy      = (state_q == RUN) || vld_q;

endmodule

// File: tb/tb_pep_ks_lb_sequencer.sv
// Bench for pep_ks_lb_sequencer: loop-nest model feeds a token
// scoreboard; directed steps cover sizes, stalls, errors and reset.
module tb_pep_ks_lb_sequencer;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [12:0] cmd_blwe_k = '0;
  logic [10:0] cmd_lwe_k = '0;
  logic [3:0]  cmd_lvl = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [9:0]  out_x_idx;
  logic [2:0]  out_x_nb;
  logic [11:0] out_y_idx;
  logic [6:0]  out_y_nb;
  logic [2:0]  out_z_idx;
  logic [1:0]  out_z_nb;
  logic        out_sop, out_eop, out_last;
  logic        busy, err;

  pep_ks_lb_sequencer dut (
    .clk(clk), .a_rst(a_rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_blwe_k(cmd_blwe_k), .cmd_lwe_k(cmd_lwe_k), .cmd_lvl(cmd_lvl),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_x_idx(out_x_idx), .out_x_nb(out_x_nb),
    .out_y_idx(out_y_idx), .out_y_nb(out_y_nb),
    .out_z_idx(out_z_idx), .out_z_nb(out_z_nb),
    .out_sop(out_sop), .out_eop(out_eop), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [39:0] tok;
  assign tok = {out_x_idx, out_x_nb, out_y_idx, out_y_nb,
                out_z_idx, out_z_nb, out_sop, out_eop, out_last};

  logic [39:0] q[$];
  int ntests = 0;
  int nfail  = 0;
  int npop   = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  bit rnd    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input int b, input int l, input int v);
    for (int x = 0; x < l; x += 6)
      for (int y = 0; y < b; y += 64)
        for (int z = 0; z < v; z += 3) begin
          int xn, yn, zn;
          logic s, e, t;
          xn = (l - x < 6) ? l - x : 6;
          yn = (b - y < 64) ? b - y : 64;
          zn = (v - z < 3) ? v - z : 3;
          s = (y == 0) && (z == 0);
          e = (y + 64 >= b) && (z + 3 >= v);
          t = e && (x + 6 >= l);
          q.push_back({10'(x), 3'(xn), 12'(y), 7'(yn),
                       3'(z), 2'(zn), s, e, t});
        end
  endtask

  // Called just after a posedge; returns just after the accept edge
  task automatic send(input int b, input int l, input int v,
                      input bit legal);
    cmd_blwe_k = 13'(b);
    cmd_lwe_k  = 11'(l);
    cmd_lvl    = 4'(v);
    cmd_vld    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_rdy) break;
    end
    check("cmd_rdy_wait", 64'(cmd_rdy), 64'd1);
    if (legal) push_cmd(b, l, v);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    check(tag, {31'd0, busy, 32'(q.size())}, 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rnd) out_rdy = ($urandom_range(0, 99) < 30);
  end

  // Scoreboard pop and stall-stability monitor
  initial begin
    bit          stall;
    logic [39:0] stall_tok;
    stall = 1'b0;
    stall_tok = '0;
    forever begin
      @(negedge clk);
      if (a_rst) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("stall_stable", {23'd0, out_vld, tok},
                {23'd0, 1'b1, stall_tok});
        if (out_vld && out_rdy) begin
          if (q.size() == 0) begin
            check("extra_tok", 64'(q.size()), 64'd1);
          end else begin
            logic [39:0] e;
            e = q.pop_front();
            check("tok", 64'(tok), 64'(e));
            npop++;
          end
        end
        stall = out_vld && !out_rdy;
        stall_tok = tok;
      end
    end
  end

  initial begin
    int a1;
    #2;
    @(negedge clk);
    check("rst_outs", {59'd0, out_vld, busy, err, cmd_rdy, 1'b0},
          64'd0);
    check("rst_payload", 64'(tok), 64'd0);
    @(posedge clk);
    #1 a_rst = 1'b0;
    @(posedge clk);
    #1;

    npop = 0;
    send(128, 12, 3, 1'b1);
    check("latency_vld", 64'(out_vld), 64'd1);
    drain("drain_a");
    check("count_a", 64'(npop), 64'd4);

    npop = 0;
    @(posedge clk);
    #1;
    send(130, 7, 4, 1'b1);
    drain("drain_b");
    check("count_b", 64'(npop), 64'd12);

    npop = 0;
    rnd = 1'b1;
    @(posedge clk);
    #1;
    send(130, 7, 4, 1'b1);
    drain("drain_rnd");
    check("count_rnd", 64'(npop), 64'd12);
    rnd = 1'b0;
    @(posedge clk);
    #1 out_rdy = 1'b1;

    for (int k = 0; k < 2; k++) begin
      send(64, 6, (k == 0) ? 0 : 9, 1'b0);
      @(negedge clk);
      check("err_pulse", {61'd0, err, out_vld, cmd_rdy}, 64'b101);
      @(negedge clk);
      check("err_clear", {61'd0, err, out_vld, cmd_rdy}, 64'b001);
      @(posedge clk);
      #1;
    end
    npop = 0;
    send(128, 12, 3, 1'b1);
    drain("drain_after_err");
    check("count_after_err", 64'(npop), 64'd4);

    npop = 0;
    @(posedge clk);
    #1;
    send(130, 7, 4, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (npop >= 5) break;
    end
    check("reach_5", 64'(npop), 64'd5);
    @(posedge clk);
    #1 a_rst = 1'b1;
    #1;
    check("midrst", {62'd0, out_vld, busy}, 64'd0);
    q.delete();
    @(posedge clk);
    #1 a_rst = 1'b0;
    npop = 0;
    send(130, 7, 4, 1'b1);
    check("restart_vld", 64'(out_vld), 64'd1);
    drain("drain_restart");
    check("count_restart", 64'(npop), 64'd12);

    npop = 0;
    @(posedge clk);
    #1;
    send(64, 6, 3, 1'b1);
    a1 = acc_cyc;
    send(64, 6, 3, 1'b1);
    check("b2b_accept_gap", 64'(acc_cyc - a1), 64'd1);
    drain("drain_b2b");
    check("count_b2b", 64'(npop), 64'd2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
